cesel_iter_core: RTL and testbench

//  Parametrised iterative stand-in for the CESEL crypto core on the CW305 Artix-7 target.

---
 rtl/cesel_iter_core.sv | 125 ++++++++++++
 tb/tb_cesel_iter_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cesel_iter_core.sv
// ---------------------------------------------------------------------------
// cesel_iter_core
// Iterative rotate-XOR stand-in for the CESEL cipher core (CW305 target).
// A start request latches key and plaintext. The core then runs ROUNDS rounds,
// one per clock: state <= rotl1(state) ^ key. At the end it publishes the
// ciphertext on ct and pulses done for one cycle. busy is high while the
// rounds are running.
//
// Optional feature (macro CESEL_TRIGGER_EN): adds a registered scope trigger
// output, trig. It has the same timing as busy. When the macro is undefined,
// neither the port nor its logic exists.
// ---------------------------------------------------------------------------
module cesel_iter_core #(
    parameter int WIDTH  = 128,
    parameter int ROUNDS = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] pt,
    output logic [WIDTH-1:0] ct,
    output logic             busy,
    output logic             done
`ifdef CESEL_TRIGGER_EN
   ,output logic             trig
`endif
);

    // Round counter width, derived from ROUNDS.
    localparam int CNT_W = $clog2(ROUNDS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    // Rotate left by one bit, modulo WIDTH. No width growth.
    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    fsm_t             state_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] key_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] round_s;
    logic             last_s;

    // Round datapath and last-round detection (cnt_r==1 marks the completion edge)
    always_comb begin
        round_s = rotl1(data_r) ^ key_r;
        last_s  = (cnt_r == CNT_W'(1));
    end

    // Control FSM with registered outputs; start is ignored whenever RUN is active
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            data_r  <= {WIDTH{1'b0}};
            key_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ct      <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef CESEL_TRIGGER_EN
            trig    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_r  <= pt;
                        key_r   <= key;
                        cnt_r   <= CNT_W'(ROUNDS);
                        busy    <= 1'b1;
`ifdef CESEL_TRIGGER_EN
                        trig    <= 1'b1;
`endif
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
`ifdef CESEL_TRIGGER_EN
                        trig    <= 1'b0;
`endif
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    data_r <= round_s;
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (last_s) begin
                        // Completion edge: publish the result and return to IDLE.
                        // A start sampled here is dropped, because busy is still high.
                        ct      <= round_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
`ifdef CESEL_TRIGGER_EN
                        trig    <= 1'b0;
`endif
                        state_r <= ST_IDLE;
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b1;
`ifdef CESEL_TRIGGER_EN
                        trig    <= 1'b1;
`endif
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    busy    <= 1'b0;
                    done    <= 1'b0;
`ifdef CESEL_TRIGGER_EN
                    trig    <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cesel_iter_core.sv
// ---------------------------------------------------------------------------
// tb_cesel_iter_core
// Scoreboard bench for cesel_iter_core, built with WIDTH=128 and ROUNDS=10.
// A second instance is built with ROUNDS=1 to cover the single-round case.
//
// An accept/countdown reference model pushes the expected ciphertext into a
// queue each time it accepts a start. A separate negedge monitor compares
// busy, done and ct (and trig) against that model. On every done pulse the
// monitor pops the queue and checks ct.
// ---------------------------------------------------------------------------
module tb_cesel_iter_core;

    localparam int W = 128;
    localparam int R = 10;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic [W-1:0] key    = '0;
    logic [W-1:0] pt     = '0;
    logic [W-1:0] ct;
    logic         busy;
    logic         done;

    logic         start1 = 1'b0;
    logic [W-1:0] key1   = '0;
    logic [W-1:0] pt1    = '0;
    logic [W-1:0] ct1;
    logic         busy1;
    logic         done1;
`ifdef CESEL_TRIGGER_EN
    logic         trig;
    logic         trig1;
`endif

    cesel_iter_core #(.WIDTH(W), .ROUNDS(R)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .key(key), .pt(pt),
        .ct(ct), .busy(busy), .done(done)
`ifdef CESEL_TRIGGER_EN
       ,.trig(trig)
`endif
    );

    cesel_iter_core #(.WIDTH(W), .ROUNDS(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .key(key1), .pt(pt1),
        .ct(ct1), .busy(busy1), .done(done1)
`ifdef CESEL_TRIGGER_EN
       ,.trig(trig1)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ciphertext expected after n rounds, computed straight from the round rule.
    function automatic logic [W-1:0] ref_ct(input logic [W-1:0] k, input logic [W-1:0] p, input int n);
        logic [W-1:0] s;
        s = p;
        for (int i = 0; i < n; i++) s = ((s << 1) | (s >> (W - 1))) ^ k;
        return s;
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           m_left = 0;   // rounds still to run (0 means idle)
    bit           m_done = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                exp_q.delete();
                m_left = 0;
                m_done = 1'b0;
            end else if (m_left == 0) begin
                m_done = 1'b0;
                if (start) begin
                    exp_q.push_back(ref_ct(key, pt, R));
                    m_left = R;
                end
            end else begin
                m_done = (m_left == 1);
                m_left = m_left - 1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [W-1:0] last_ct = '0;

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_ct", ct, '0);
                chk("rst_busy", W'(busy), '0);
                chk("rst_done", W'(done), '0);
`ifdef CESEL_TRIGGER_EN
                chk("rst_trig", W'(trig), '0);
`endif
                last_ct = '0;
            end else begin
                chk("busy", W'(busy), W'(m_left != 0));
                chk("done", W'(done), W'(m_done));
`ifdef CESEL_TRIGGER_EN
                chk("trig", W'(trig), W'(m_left != 0));
`endif
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("ct_unexpected_done", W'(1), W'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("ct_done", ct, e);
                        last_ct = e;
                    end
                end else begin
                    chk("ct_hold", ct, last_ct);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;

        // 1: reset held with start high, then release; start is still high
        // for one sampled edge (key=0, pt=1 -> ct=0x400)
        start = 1'b1; key = '0; pt = W'(1);
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        start = 1'b0;

        // 2: known answer for key=0, pt=1, with a bounded wait for done
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("t2_done_seen", W'(seen), W'(1));
        if (seen) chk("t2_ct", ct, 128'h400);
        tick();

        // 3: ROUNDS=1 instance, where ct must equal key
        key1   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        pt1    = '0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t3_busy", W'(busy1), W'(1));
        chk("t3_done0", W'(done1), W'(0));
        tick();
        chk("t3_done", W'(done1), W'(1));
        chk("t3_busy0", W'(busy1), W'(0));
        chk("t3_ct", ct1, 128'hdeadbeef_deadbeef_deadbeef_deadbeef);
        tick();
        chk("t3_done_clr", W'(done1), W'(0));
        chk("t3_ct_hold", ct1, 128'hdeadbeef_deadbeef_deadbeef_deadbeef);

        // 4: start re-pulsed during RUN (including the completion edge) while key/pt change
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        start = 1'b1;
        tick();
        for (int j = 1; j <= R + 1; j++) begin
            start = (j == 3 || j == R);
            key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        start = 1'b0;
        repeat (3) tick();

        // random traffic: start and data toggled randomly each cycle
        for (int c = 0; c < 300; c++) begin
            start = ($urandom_range(0, 3) == 0);
            key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        start = 1'b0;
        repeat (R + 2) tick();

        // 5: start held high for 30 cycles gives back-to-back operations
        key = '0; pt = W'(1); start = 1'b1;
        repeat (30) tick();
        start = 1'b0;
        repeat (R + 2) tick();

        // 6: asynchronous reset at cycle 5 of RUN aborts the op without a done pulse
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        chk("t6_ct", ct, '0);
        chk("t6_busy", W'(busy), '0);
        chk("t6_done", W'(done), '0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (R + 3) tick();

        // every accepted operation must have completed
        chk("queue_empty", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
